// File: rtl/mem_bus_master.sv
`default_nettype none
// =============================================================================
// Module   : mem_bus_master
// Purpose  : Single-outstanding request/response bridge onto a simple SRAM-style
//            bus; one-cycle writes, READ_WAIT-cycle reads.
// Revision : 1.0 - initial release
// =============================================================================
module mem_bus_master #(
    parameter int READ_WAIT = 2
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_wr,
    input  logic [15:0] req_addr,
    input  logic [15:0] req_wdata,
    output logic        rsp_valid,
    input  logic        rsp_ready,
    output logic [15:0] rsp_rdata,
    output logic [15:0] cpu_addr,
    output logic        cpu_mem_ena,
    output logic        cpu_wr_ena,
    output logic [15:0] cpu_wdata,
    input  logic [15:0] cpu_rdata,
    output logic        busy
);

    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        RD_ACCESS = 2'd1,
        WR_ACCESS = 2'd2,
        RESP      = 2'd3
    } state_t;

    localparam logic [3:0] c_rd_load = 4'(READ_WAIT - 1);

    state_t      state_q, state_d;
    logic [15:0] addr_q,  addr_d;
    logic [15:0] wdata_q, wdata_d;
    logic [15:0] rdata_q, rdata_d;
    logic [3:0]  cnt_q,   cnt_d;

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= IDLE;
            addr_q  <= 16'h0000;
            wdata_q <= 16'h0000;
            rdata_q <= 16'h0000;
            cnt_q   <= 4'd0;
        end else begin
            state_q <= state_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            rdata_q <= rdata_d;
            cnt_q   <= cnt_d;
        end
    end

    always_comb begin
        state_d = state_q;
        addr_d  = addr_q;
        wdata_d = wdata_q;
        rdata_d = rdata_q;
        cnt_d   = cnt_q;
        unique case (state_q)
            IDLE: begin
                if (req_valid) begin
                    addr_d  = req_addr;
                    wdata_d = req_wdata;
                    cnt_d   = req_wr ? 4'd0 : c_rd_load;
                    state_d = req_wr ? WR_ACCESS : RD_ACCESS;
                end
            end
            RD_ACCESS: begin
                // Bus data is only trusted on the last enabled cycle.
                if (cnt_q == 4'd0) begin
                    rdata_d = cpu_rdata;
                    state_d = RESP;
                end else begin
                    cnt_d = cnt_q - 4'd1;
                end
            end
            WR_ACCESS: begin
                rdata_d = 16'h0000;
                state_d = RESP;
            end
            RESP: begin
                if (rsp_ready) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // Handshake and strobe outputs come from the state register alone.
    assign req_ready   = (state_q == IDLE);
    assign busy        = (state_q != IDLE);
    assign cpu_mem_ena = (state_q == RD_ACCESS) || (state_q == WR_ACCESS);
    assign cpu_wr_ena  = (state_q == WR_ACCESS);
    assign rsp_valid   = (state_q == RESP);
    assign rsp_rdata   = rdata_q;
    assign cpu_addr    = addr_q;
    assign cpu_wdata   = wdata_q;

endmodule
`default_nettype wire

// File: tb/tb_mem_bus_master.sv
`default_nettype none
// =============================================================================
// Module   : tb_mem_bus_master
// Purpose  : Two instances (READ_WAIT=2 and 3) driven in lockstep and compared
//            every cycle against a transaction-age reference model.
// Revision : 1.0 - initial release
// =============================================================================
module tb_mem_bus_master;

    localparam int RW0 = 2;
    localparam int RW1 = 3;

    logic        clk = 1'b0;
    logic        reset;
    logic        req_valid, req_wr, rsp_ready;
    logic [15:0] req_addr, req_wdata, bus_data;

    logic [1:0]  d_req_ready, d_rsp_valid, d_ena, d_wr_ena, d_busy;
    logic [15:0] d_rsp_rdata [2];
    logic [15:0] d_cpu_addr  [2];
    logic [15:0] d_cpu_wdata [2];
    logic [15:0] d_cpu_rdata [2];

    int checks = 0;
    int errors = 0;
    logic check_en = 1'b0;

    // Reference model: each transaction has an age (1 = first cycle after accept).
    logic        m_act   [2];
    int          m_age   [2];
    logic        m_wr    [2];
    logic [15:0] m_addr  [2];
    logic [15:0] m_wdata [2];
    logic [15:0] m_rdata [2];

    always #5 clk = ~clk;

    mem_bus_master #(.READ_WAIT(RW0)) u_dut0 (
        .clk(clk), .reset(reset), .req_valid(req_valid), .req_ready(d_req_ready[0]),
        .req_wr(req_wr), .req_addr(req_addr), .req_wdata(req_wdata),
        .rsp_valid(d_rsp_valid[0]), .rsp_ready(rsp_ready), .rsp_rdata(d_rsp_rdata[0]),
        .cpu_addr(d_cpu_addr[0]), .cpu_mem_ena(d_ena[0]), .cpu_wr_ena(d_wr_ena[0]),
        .cpu_wdata(d_cpu_wdata[0]), .cpu_rdata(d_cpu_rdata[0]), .busy(d_busy[0])
    );

    mem_bus_master #(.READ_WAIT(RW1)) u_dut1 (
        .clk(clk), .reset(reset), .req_valid(req_valid), .req_ready(d_req_ready[1]),
        .req_wr(req_wr), .req_addr(req_addr), .req_wdata(req_wdata),
        .rsp_valid(d_rsp_valid[1]), .rsp_ready(rsp_ready), .rsp_rdata(d_rsp_rdata[1]),
        .cpu_addr(d_cpu_addr[1]), .cpu_mem_ena(d_ena[1]), .cpu_wr_ena(d_wr_ena[1]),
        .cpu_wdata(d_cpu_wdata[1]), .cpu_rdata(d_cpu_rdata[1]), .busy(d_busy[1])
    );

    function automatic int lat(int i, logic wr);
        if (wr) return 1;
        return (i == 0) ? RW0 : RW1;
    endfunction

    // Bus returns the real data only on the final access cycle, garbage otherwise.
    assign d_cpu_rdata[0] = (m_act[0] && !m_wr[0] && m_age[0] == RW0) ? bus_data : ~bus_data;
    assign d_cpu_rdata[1] = (m_act[1] && !m_wr[1] && m_age[1] == RW1) ? bus_data : ~bus_data;

    always @(posedge clk) begin
        for (int i = 0; i < 2; i++) begin
            if (reset) begin
                m_act[i]   <= 1'b0;
                m_age[i]   <= 0;
                m_wr[i]    <= 1'b0;
                m_addr[i]  <= 16'h0000;
                m_wdata[i] <= 16'h0000;
                m_rdata[i] <= 16'h0000;
            end else if (!m_act[i]) begin
                if (req_valid) begin
                    m_act[i]   <= 1'b1;
                    m_age[i]   <= 1;
                    m_wr[i]    <= req_wr;
                    m_addr[i]  <= req_addr;
                    m_wdata[i] <= req_wdata;
                end
            end else begin
                if (m_age[i] == lat(i, m_wr[i]))
                    m_rdata[i] <= m_wr[i] ? 16'h0000 : bus_data;
                if (m_age[i] > lat(i, m_wr[i]) && rsp_ready)
                    m_act[i] <= 1'b0;
                else
                    m_age[i] <= m_age[i] + 1;
            end
        end
    end

    task automatic chk(input string nm, input logic [15:0] act, input logic [15:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s at %0t: got %h, expected %h", nm, $time, act, exp);
        end
    endtask

    always @(negedge clk) begin
        if (check_en) begin
            for (int i = 0; i < 2; i++) begin
                logic e_ena, e_rv;
                e_ena = m_act[i] && (m_age[i] <= lat(i, m_wr[i]));
                e_rv  = m_act[i] && (m_age[i] >  lat(i, m_wr[i]));
                chk($sformatf("d%0d.req_ready", i), {15'd0, d_req_ready[i]}, {15'd0, !m_act[i]});
                chk($sformatf("d%0d.busy", i), {15'd0, d_busy[i]}, {15'd0, m_act[i]});
                chk($sformatf("d%0d.cpu_mem_ena", i), {15'd0, d_ena[i]}, {15'd0, e_ena});
                chk($sformatf("d%0d.cpu_wr_ena", i), {15'd0, d_wr_ena[i]}, {15'd0, e_ena && m_wr[i]});
                chk($sformatf("d%0d.rsp_valid", i), {15'd0, d_rsp_valid[i]}, {15'd0, e_rv});
                chk($sformatf("d%0d.cpu_addr", i), d_cpu_addr[i], m_addr[i]);
                chk($sformatf("d%0d.cpu_wdata", i), d_cpu_wdata[i], m_wdata[i]);
                if (e_rv)
                    chk($sformatf("d%0d.rsp_rdata", i), d_rsp_rdata[i], m_rdata[i]);
            end
        end
    end

    task automatic tick();
        @(negedge clk);
    endtask

    task automatic offer(input logic wr, input logic [15:0] addr, input logic [15:0] wd);
        req_valid = 1'b1;
        req_wr    = wr;
        req_addr  = addr;
        req_wdata = wd;
    endtask

    task automatic wait_idle();
        int n = 0;
        while (d_req_ready != 2'b11 && n < 60) begin
            tick();
            n++;
        end
        chk("wait_idle_timeout", {15'd0, d_req_ready == 2'b11}, 16'd1);
    endtask

    initial begin
        int cnt0, cnt1;
        reset = 1'b1; req_valid = 1'b0; req_wr = 1'b0; req_addr = '0; req_wdata = '0;
        rsp_ready = 1'b1; bus_data = 16'hBEEF;
        tick(); tick();
        // Reset state
        chk("rst.req_ready", {14'd0, d_req_ready}, 16'h0003);
        chk("rst.rsp_valid", {14'd0, d_rsp_valid}, 16'h0000);
        chk("rst.mem_ena", {14'd0, d_ena}, 16'h0000);
        chk("rst.busy", {14'd0, d_busy}, 16'h0000);
        chk("rst.cpu_addr", d_cpu_addr[0], 16'h0000);
        chk("rst.rsp_rdata", d_rsp_rdata[1], 16'h0000);
        reset = 1'b0;
        check_en = 1'b1;

        // Directed write
        offer(1'b1, 16'h0010, 16'hBEEF);
        tick(); req_valid = 1'b0;
        chk("wr.k1.ena", {14'd0, d_ena}, 16'h0003);
        chk("wr.k1.wr_ena", {14'd0, d_wr_ena}, 16'h0003);
        chk("wr.k1.addr", d_cpu_addr[0], 16'h0010);
        chk("wr.k1.wdata", d_cpu_wdata[1], 16'hBEEF);
        tick();
        chk("wr.k2.rsp_valid", {14'd0, d_rsp_valid}, 16'h0003);
        chk("wr.k2.rdata", d_rsp_rdata[0], 16'h0000);
        tick();
        chk("wr.k3.req_ready", {14'd0, d_req_ready}, 16'h0003);

        // Directed read, BEEF returned
        bus_data = 16'hBEEF;
        offer(1'b0, 16'h0010, 16'h0000);
        tick(); req_valid = 1'b0;
        chk("rd.k1.ena", {14'd0, d_ena}, 16'h0003);
        chk("rd.k1.wr_ena", {14'd0, d_wr_ena}, 16'h0000);
        tick();
        chk("rd.k2.ena0", {15'd0, d_ena[0]}, 16'h0001);
        tick();
        chk("rd.k3.rsp_valid0", {15'd0, d_rsp_valid[0]}, 16'h0001);
        chk("rd.k3.rdata0", d_rsp_rdata[0], 16'hBEEF);
        chk("rd.k3.ena1", {15'd0, d_ena[1]}, 16'h0001);
        tick();
        chk("rd.k4.rdata1", d_rsp_rdata[1], 16'hBEEF);
        wait_idle();

        // Backpressure
        rsp_ready = 1'b0;
        bus_data = 16'h1234;
        offer(1'b0, 16'h1234, 16'h0000);
        tick(); req_valid = 1'b0;
        tick(); tick(); tick();
        for (int j = 0; j < 5; j++) begin
            chk("bp.rsp_valid", {14'd0, d_rsp_valid}, 16'h0003);
            chk("bp.rdata0", d_rsp_rdata[0], 16'h1234);
            chk("bp.ena", {14'd0, d_ena}, 16'h0000);
            chk("bp.req_ready", {14'd0, d_req_ready}, 16'h0000);
            tick();
        end
        rsp_ready = 1'b1;
        tick();
        chk("bp.release.req_ready", {14'd0, d_req_ready}, 16'h0003);

        // Busy drop: second request during access is ignored
        bus_data = 16'h5555;
        offer(1'b0, 16'h0010, 16'h0000);
        cnt0 = 0; cnt1 = 0;
        for (int j = 0; j < 8; j++) begin
            tick();
            req_valid = (j == 0);
            req_addr  = (j == 0) ? 16'h0020 : 16'h0010;
            cnt0 += int'(d_ena[0]);
            cnt1 += int'(d_ena[1]);
        end
        req_valid = 1'b0;
        chk("drop.ena_cycles0", 16'(cnt0), 16'd2);
        chk("drop.ena_cycles1", 16'(cnt1), 16'd3);
        chk("drop.cpu_addr", d_cpu_addr[1], 16'h0010);
        wait_idle();

        // Reset in the 2nd access cycle, with a request offered alongside reset
        bus_data = 16'h7777;
        offer(1'b0, 16'h0040, 16'h0000);
        tick(); req_valid = 1'b0;
        tick();
        reset = 1'b1;
        offer(1'b0, 16'h0050, 16'h0000);
        tick();
        reset = 1'b0; req_valid = 1'b0;
        chk("rstmid.ena1", {15'd0, d_ena[1]}, 16'h0000);
        chk("rstmid.rsp_valid", {14'd0, d_rsp_valid}, 16'h0000);
        chk("rstmid.req_ready", {14'd0, d_req_ready}, 16'h0003);
        tick();
        chk("rstmid.not_accepted", {14'd0, d_req_ready}, 16'h0003);
        chk("rstmid.cpu_addr", d_cpu_addr[1], 16'h0000);
        offer(1'b0, 16'h0040, 16'h0000);
        tick(); req_valid = 1'b0;
        tick(); tick(); tick();
        chk("rstmid.reread.rdata1", d_rsp_rdata[1], 16'h7777);
        wait_idle();

        // I/O address FFFF
        offer(1'b1, 16'hFFFF, 16'h00A5);
        tick(); req_valid = 1'b0;
        chk("io.wr.addr", d_cpu_addr[0], 16'hFFFF);
        chk("io.wr.wdata", d_cpu_wdata[0], 16'h00A5);
        chk("io.wr.wr_ena", {14'd0, d_wr_ena}, 16'h0003);
        wait_idle();
        bus_data = 16'h00A5;
        offer(1'b0, 16'hFFFF, 16'h0000);
        tick(); req_valid = 1'b0;
        chk("io.rd.addr", d_cpu_addr[1], 16'hFFFF);
        tick(); tick();
        chk("io.rd.rdata0", d_rsp_rdata[0], 16'h00A5);
        wait_idle();

        // Randomized traffic
        for (int j = 0; j < 3000; j++) begin
            reset     = ($urandom_range(99) == 0);
            req_valid = ($urandom_range(1) == 1);
            req_wr    = ($urandom_range(1) == 1);
            req_addr  = 16'($urandom);
            req_wdata = 16'($urandom);
            rsp_ready = ($urandom_range(9) < 7);
            bus_data  = 16'($urandom);
            tick();
        end
        reset = 1'b0; req_valid = 1'b0; rsp_ready = 1'b1;
        tick(); tick();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/mem_bus_master.md
MEM_BUS_MASTER -- requirements
Module: mem_bus_master

Interface
REQ-001 The block SHALL have parameter READ_WAIT, default 2, giving the number of cycles cpu_mem_ena is held for a read (legal 1..15).
REQ-002 The block SHALL have these ports:
- clk  input  1  rising-edge clock
- reset  input  1  synchronous, active-high reset
- req_valid  input  1  request offered
- req_ready  output  1  block can accept a request
- req_wr  input  1  1 = write, 0 = read
- req_addr  input  16  request address
- req_wdata  input  16  write data
- rsp_valid  output  1  response available
- rsp_ready  input  1  consumer accepts the response
- rsp_rdata  output  16  read data; 0 for writes
- cpu_addr  output  16  bus address
- cpu_mem_ena  output  1  bus access enable
- cpu_wr_ena  output  1  bus write enable
- cpu_wdata  output  16  bus write data
- cpu_rdata  input  16  bus read data, valid combinationally while cpu_mem_ena=1
- busy  output  1  high in any state other than IDLE

Function
REQ-003 The block SHALL implement the FSM states IDLE, RD_ACCESS, WR_ACCESS and RESP.
REQ-004 req_ready SHALL be 1 exactly in IDLE, and a request SHALL be accepted on a rising edge where req_valid=1 and req_ready=1.
REQ-005 On acceptance, req_addr, req_wr and req_wdata SHALL be registered, and the FSM SHALL go to WR_ACCESS if req_wr=1, otherwise RD_ACCESS.
REQ-006 In WR_ACCESS the block SHALL drive cpu_mem_ena=1, cpu_wr_ena=1, and the registered addr/wdata for exactly 1 cycle, then go to RESP.
REQ-007 In RD_ACCESS the block SHALL drive cpu_mem_ena=1 and cpu_wr_ena=0 for exactly READ_WAIT cycles, counted by a 4-bit down counter loaded with READ_WAIT-1 on acceptance.
REQ-008 On the final RD_ACCESS cycle (counter=0), the block SHALL capture cpu_rdata into rsp_rdata and go to RESP.
REQ-009 In IDLE and RESP, cpu_mem_ena and cpu_wr_ena SHALL be 0.
REQ-010 cpu_addr and cpu_wdata SHALL hold the last registered request values outside access states; these values are don't-care for the bus.
REQ-011 In RESP, rsp_valid SHALL be 1 and rsp_rdata stable until the edge where rsp_ready=1; the FSM SHALL then go to IDLE.
REQ-012 For a write response, rsp_rdata SHALL be 16'h0000.
REQ-013 Latency from accept edge k SHALL be: write, cpu_wr_ena high during cycle k+1 and rsp_valid from cycle k+2; read, cpu_mem_ena high during cycles k+1..k+READ_WAIT and rsp_valid from cycle k+READ_WAIT+1.
REQ-014 Only one transaction SHALL be outstanding; req_valid during busy SHALL be ignored and not queued.
REQ-015 If rsp_ready is already 1 when RESP is entered, the block SHALL spend exactly 1 cycle in RESP, giving a minimum request-to-request spacing of 3 cycles (write) or READ_WAIT+2 cycles (read).
REQ-016 Address 16'hFFFF SHALL receive no special treatment; the block is transparent to the I/O decode downstream.
REQ-017 Outputs cpu_mem_ena, cpu_wr_ena, rsp_valid and req_ready SHALL be decoded from the registered state only, with no combinational path from req_* or rsp_ready.

Reset
REQ-018 On reset the block SHALL go to IDLE and set req_ready=1, rsp_valid=0, rsp_rdata=0, cpu_mem_ena=0, cpu_wr_ena=0, cpu_addr=0, cpu_wdata=0, busy=0, and counter=0.
REQ-019 Reset asserted in any state SHALL abandon the transaction: no further bus cycle and no response, with cpu_mem_ena=0 from the cycle after the reset edge.
REQ-020 A request presented in the same cycle as reset SHALL NOT be accepted.

Verification
REQ-021 The bench SHALL cover the following directed scenarios:
- Write: req addr=16'h0010, wdata=16'hBEEF, wr=1 -> one cycle with cpu_mem_ena=1, cpu_wr_ena=1, cpu_addr=0010, cpu_wdata=BEEF; rsp_valid at k+2 with rsp_rdata=0000.
- Read, READ_WAIT=2: req addr=16'h0010, cpu_rdata model returns BEEF -> cpu_mem_ena high 2 cycles with cpu_wr_ena=0; rsp_valid at k+3 with rsp_rdata=BEEF.
- Backpressure: hold rsp_ready=0 for 5 cycles after a read of 16'h1234 -> rsp_valid and rsp_rdata=1234 stable for 5 cycles, req_ready=0, no bus activity; IDLE one cycle after rsp_ready=1.
- Busy drop: assert req_valid with addr 16'h0020 while in RD_ACCESS -> ignored; no second bus cycle occurs and req_ready stays 0 until RESP completes.
- Reset mid-read (READ_WAIT=3, reset in the 2nd access cycle) -> cpu_mem_ena=0 and rsp_valid=0 next cycle; req_ready=1; a subsequent read completes normally.
- I/O address: write 16'h00A5 to 16'hFFFF, then read 16'hFFFF -> bus cycles identical in form to SRAM addresses; rsp_rdata equals the cpu_rdata driven by the model.
